// File: rtl/lab5_hamming_tx.sv
// lab5_hamming_tx
// ---------------------------------------------------------------------------
// Purpose:
//   Hamming(7,4) encoder and UART-style serial transmitter. This is the sending
//   end for the lab4 Hamming decoder. On a rising edge of `send` it does the
//   following:
//     - latches the data nibble sw[3:0];
//     - encodes the nibble into a 7-bit codeword, optionally flipping one bit
//       selected by sw[6:4];
//     - shows the codeword on `led`;
//     - shifts it out LSB first as the frame: start(0), 7 code bits, stop(1).
//   The latched nibble is shown as hex on the rightmost 7-segment digit.
//
// Ports:
//   clk      in   1  system clock, all state changes on the rising edge
//   rst_n    in   1  synchronous active-low reset
//   sw       in   7  [3:0] data nibble, [6:4] inject position (0 = none,
//                    k = flip code bit k-1)
//   send     in   1  transmit request level; the rising edge starts a frame
//   tx       out  1  serial line, idle high
//   busy     out  1  high while a frame is in progress
//   done     out  1  one-cycle pulse when the frame completes
//   led      out  7  post-injection codeword of the last accepted frame
//   an       out  4  digit anodes, active-low (only the rightmost is enabled)
//   cathode  out  7  segments {g,f,e,d,c,b,a}, active-low
//
// Request / status handshake:
//   A request is send=1 at a clock edge where send was 0 at the previous edge.
//   It is accepted only while busy=0. Acceptance is visible right after that
//   edge as busy=1 and tx=0. Requests seen while busy=1 are dropped, not
//   queued. This includes a request on the same edge that ends the frame.
//   busy falls on the edge 9*CLKS_PER_BIT after acceptance. On that same edge
//   done pulses high for exactly one cycle.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module lab5_hamming_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] sw,
  input  logic       send,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic [6:0] led,
  output logic [3:0] an,
  output logic [6:0] cathode
);

  localparam int             CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // Registers
  state_t        r_state;
  logic [CW-1:0] r_baud;
  logic [2:0]    r_idx;
  logic [6:0]    r_shift;
  logic          r_tx;
  logic          r_busy;
  logic          r_done;
  logic [6:0]    r_led;
  logic [3:0]    r_nibble;
  logic          r_send_d;

  // Next-state wires
  state_t        w_state_nxt;
  logic [CW-1:0] w_baud_nxt;
  logic [2:0]    w_idx_nxt;
  logic [6:0]    w_shift_nxt;
  logic          w_tx_nxt;
  logic          w_busy_nxt;
  logic          w_done_nxt;
  logic [6:0]    w_led_nxt;
  logic [3:0]    w_nibble_nxt;

  // Encoder. Code bit i carries Hamming position i+1: {d3,d2,d1,p4,d0,p2,p1}.
  logic       w_p1;
  logic       w_p2;
  logic       w_p4;
  logic [6:0] w_code;
  logic [6:0] w_flip;
  logic [6:0] w_code_inj;
  logic       w_req;
  logic       w_bit_end;

  assign w_p1   = sw[0] ^ sw[1] ^ sw[3];
  assign w_p2   = sw[0] ^ sw[2] ^ sw[3];
  assign w_p4   = sw[1] ^ sw[2] ^ sw[3];
  assign w_code = {sw[3], sw[2], sw[1], w_p4, sw[0], w_p2, w_p1};

  // Inject position k (1..7) flips code bit k-1. k = 0 leaves the code clean.
  always_comb begin
    w_flip = '0;
    if (sw[6:4] != 3'd0) begin
      w_flip[sw[6:4] - 3'd1] = 1'b1;
    end
  end

  assign w_code_inj = w_code ^ w_flip;
  assign w_req      = send & ~r_send_d;
  assign w_bit_end  = (r_baud == BAUD_LAST);

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_led    <= '0;
      r_nibble <= '0;
      r_send_d <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_baud   <= w_baud_nxt;
      r_idx    <= w_idx_nxt;
      r_shift  <= w_shift_nxt;
      r_tx     <= w_tx_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_led    <= w_led_nxt;
      r_nibble <= w_nibble_nxt;
      r_send_d <= send;
    end
  end

  // Next-state logic. tx and busy are computed one edge early so that the
  // registered outputs change on the same edge as the state.
  always_comb begin
    w_state_nxt  = r_state;
    w_baud_nxt   = r_baud + CW'(1);
    w_idx_nxt    = r_idx;
    w_shift_nxt  = r_shift;
    w_tx_nxt     = r_tx;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_led_nxt    = r_led;
    w_nibble_nxt = r_nibble;

    case (r_state)
      S_IDLE: begin
        w_baud_nxt = '0;
        w_tx_nxt   = 1'b1;
        w_busy_nxt = 1'b0;
        if (w_req) begin
          w_state_nxt  = S_START;
          w_tx_nxt     = 1'b0;
          w_busy_nxt   = 1'b1;
          w_shift_nxt  = w_code_inj;
          w_led_nxt    = w_code_inj;
          w_nibble_nxt = sw[3:0];
        end
      end

      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_baud_nxt  = '0;
          w_idx_nxt   = 3'd0;
          w_tx_nxt    = r_shift[0];
        end
      end

      S_DATA: begin
        if (w_bit_end) begin
          w_baud_nxt = '0;
          if (r_idx == 3'd6) begin
            w_state_nxt = S_STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            // Bit 1 of the current shift value becomes bit 0 after the shift.
            w_idx_nxt   = r_idx + 3'd1;
            w_shift_nxt = r_shift >> 1;
            w_tx_nxt    = r_shift[1];
          end
        end
      end

      S_STOP: begin
        if (w_bit_end) begin
          w_state_nxt = S_IDLE;
          w_baud_nxt  = '0;
          w_tx_nxt    = 1'b1;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_baud_nxt  = '0;
        w_tx_nxt    = 1'b1;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // Hex decoder for the latched nibble, active-low {g,f,e,d,c,b,a}.
  always_comb begin
    cathode = 7'b1111111;
    case (r_nibble)
      4'h0: cathode = 7'b1000000;
      4'h1: cathode = 7'b1111001;
      4'h2: cathode = 7'b0100100;
      4'h3: cathode = 7'b0110000;
      4'h4: cathode = 7'b0011001;
      4'h5: cathode = 7'b0010010;
      4'h6: cathode = 7'b0000010;
      4'h7: cathode = 7'b1111000;
      4'h8: cathode = 7'b0000000;
      4'h9: cathode = 7'b0010000;
      4'hA: cathode = 7'b0001000;
      4'hB: cathode = 7'b0000011;
      4'hC: cathode = 7'b1000110;
      4'hD: cathode = 7'b0100001;
      4'hE: cathode = 7'b0000110;
      4'hF: cathode = 7'b0001110;
      default: cathode = 7'b1111111;
    endcase
  end

  assign an   = 4'b1110;
  assign tx   = r_tx;
  assign busy = r_busy;
  assign done = r_done;
  assign led  = r_led;

endmodule

// File: tb/tb_lab5_hamming_tx.sv
// tb_lab5_hamming_tx
// Bench for lab5_hamming_tx with CLKS_PER_BIT = 4. A behavioural frame model
// turns each accepted request into a queue of expected per-cycle tx levels.
// A compare process checks every DUT output against that model on each
// falling edge. Directed sequences add literal checks for the main cases.
`timescale 1ns/1ps

module tb_lab5_hamming_tx;

  localparam int N        = 4;
  localparam int FRAME    = 9 * N;
  localparam int BUSY_MAX = 100;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] sw;
  logic       send;
  logic       tx;
  logic       busy;
  logic       done;
  logic [6:0] led;
  logic [3:0] an;
  logic [6:0] cathode;

  always #5 clk = ~clk;

  lab5_hamming_tx #(.CLKS_PER_BIT(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sw      (sw),
    .send    (send),
    .tx      (tx),
    .busy    (busy),
    .done    (done),
    .led     (led),
    .an      (an),
    .cathode (cathode)
  );

  // ---------------- counters and check helper ----------------
  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference functions ----------------
  // Parity by Hamming positions. Data goes to positions 3,5,6,7. The parity
  // at position 2^b covers every other position whose index has bit b set.
  function automatic logic [6:0] model_code(input logic [3:0] d, input logic [2:0] k);
    logic [6:0] c;
    logic       x;
    int         pp;
    c    = '0;
    c[2] = d[0];
    c[4] = d[1];
    c[5] = d[2];
    c[6] = d[3];
    for (int b = 0; b < 3; b++) begin
      pp = 1 << b;
      x  = 1'b0;
      for (int p = 1; p <= 7; p++)
        if (p != pp && (p & pp) != 0) x = x ^ c[p-1];
      c[pp-1] = x;
    end
    if (k != 3'd0) c[int'(k) - 1] = ~c[int'(k) - 1];
    return c;
  endfunction

  // Syndrome decoder: the XOR of the positions of all set bits names the bad bit.
  function automatic logic [3:0] model_decode(input logic [6:0] cw);
    logic [6:0] c;
    int         s;
    c = cw;
    s = 0;
    for (int p = 1; p <= 7; p++)
      if (c[p-1]) s = s ^ p;
    if (s != 0) c[s-1] = ~c[s-1];
    return {c[6], c[5], c[4], c[2]};
  endfunction

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // ---------------- behavioural model ----------------
  logic [0:0] exp_q[$];      // expected tx level for each remaining frame cycle
  logic [6:0] m_led;
  logic [3:0] m_nib;
  logic       m_done;
  logic       m_send_d;
  logic       m_was_busy;
  logic [6:0] m_code;
  logic [0:0] m_bit;

  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_led    = '0;
      m_nib    = '0;
      m_done   = 1'b0;
      m_send_d = 1'b0;
    end else begin
      m_was_busy = (exp_q.size() != 0);
      if (m_was_busy) void'(exp_q.pop_front());
      m_done = m_was_busy && (exp_q.size() == 0);
      if (!m_was_busy && send && !m_send_d) begin
        m_code = model_code(sw[3:0], sw[6:4]);
        m_led  = m_code;
        m_nib  = sw[3:0];
        for (int k = 0; k < 9; k++) begin
          if (k == 0)      m_bit = 1'b0;
          else if (k == 8) m_bit = 1'b1;
          else             m_bit = m_code[k-1];
          for (int c = 0; c < N; c++) exp_q.push_back(m_bit);
        end
      end
      m_send_d = send;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("tx",      {31'd0, tx},   (exp_q.size() != 0) ? {31'd0, exp_q[0]} : 32'd1);
      check("busy",    {31'd0, busy}, (exp_q.size() != 0) ? 32'd1 : 32'd0);
      check("done",    {31'd0, done}, {31'd0, m_done});
      check("led",     {25'd0, led},  {25'd0, m_led});
      check("cathode", {25'd0, cathode}, {25'd0, seg_tab[m_nib]});
      check("an",      {28'd0, an},   32'h0000000E);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_frame(input logic [6:0] s, output logic [8:0] bits,
                            output int cyc, output logic dn);
    bits = '0;
    cyc  = 0;
    @(negedge clk);
    sw   = s;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    while (busy && cyc < BUSY_MAX) begin
      if (cyc % N == 0 && cyc / N < 9) bits[cyc / N] = tx;
      if (cyc == 2) sw = ~s;    // a frame in flight must not see sw changes
      cyc++;
      @(negedge clk);
    end
    dn = done;
    check("busy_bound", {31'd0, (cyc < BUSY_MAX)}, 32'd1);
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (busy && c < BUSY_MAX) begin
      c++;
      @(negedge clk);
    end
    check("idle_bound", {31'd0, busy}, 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [8:0] bits;
    int         cyc;
    logic       dn;
    int         rises;
    logic       prev;
    logic [6:0] code;

    rst_n = 1'b0;
    send  = 1'b0;
    sw    = '0;

    // Hand-computed values that pin the reference functions.
    check("pin_code_B",    {25'd0, model_code(4'hB, 3'd0)}, 32'h55);   // 1010101
    check("pin_code_1",    {25'd0, model_code(4'h1, 3'd0)}, 32'h07);   // 0000111
    check("pin_code_1_k3", {25'd0, model_code(4'h1, 3'd3)}, 32'h03);   // 0000011
    check("pin_decode",    {28'd0, model_decode(7'b1011101)}, 32'hB);

    // Test 1: reset held for 3 cycles while send toggles.
    @(posedge clk);
    chk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_tx",      {31'd0, tx},   32'd1);
      check("rst_busy",    {31'd0, busy}, 32'd0);
      check("rst_done",    {31'd0, done}, 32'd0);
      check("rst_led",     {25'd0, led},  32'd0);
      check("rst_cathode", {25'd0, cathode}, 32'h40);
      check("rst_an",      {28'd0, an},   32'hE);
      send = ~send;
    end
    send  = 1'b0;
    rst_n = 1'b1;

    // Test 2: nibble B, no injection.
    send_frame(7'b000_1011, bits, cyc, dn);
    check("t2_led",     {25'd0, led}, 32'h55);
    check("t2_bits",    {23'd0, bits}, {23'd0, 9'b1_1010101_0});
    check("t2_busy",    cyc, FRAME);
    check("t2_done",    {31'd0, dn}, 32'd1);
    check("t2_cathode", {25'd0, cathode}, 32'h03);

    // Test 3: nibble 1 with bit 2 flipped.
    send_frame(7'b011_0001, bits, cyc, dn);
    check("t3_led",  {25'd0, led}, 32'h03);
    check("t3_data", {25'd0, bits[7:1]}, 32'h03);

    // Test 4a: a second rising edge at cycle 10 of the frame is ignored.
    @(negedge clk);
    sw    = 7'h05;
    send  = 1'b1;
    @(negedge clk);
    send  = 1'b0;
    rises = 0;
    prev  = 1'b0;
    for (int c = 0; c < 120; c++) begin
      if (busy && !prev) rises++;
      prev = busy;
      if (c == 9)  send = 1'b1;
      if (c == 10) send = 1'b0;
      @(negedge clk);
    end
    check("t4a_frames", rises, 1);

    // Test 4b: send held across the end of the frame gives one frame only.
    sw    = 7'h0A;
    send  = 1'b1;
    rises = 0;
    prev  = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (busy && !prev) rises++;
      prev = busy;
    end
    check("t4b_frames", rises, 1);
    check("t4b_idle",   {31'd0, busy}, 32'd0);
    send = 1'b0;
    @(negedge clk);
    send = 1'b1;
    @(negedge clk);
    check("t4b_repress", {31'd0, busy}, 32'd1);
    send = 1'b0;
    wait_idle();

    // Test 5: reset during DATA bit index 3.
    @(negedge clk);
    sw   = 7'b000_1110;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    repeat (4 * N + 1) @(negedge clk);
    check("t5_in_frame", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_tx",   {31'd0, tx},   32'd1);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_led",  {25'd0, led},  32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(7'b000_0110, bits, cyc, dn);
    code = model_code(4'h6, 3'd0);
    check("t5_led2",  {25'd0, led}, {25'd0, code});
    check("t5_bits2", {23'd0, bits}, {23'd0, 1'b1, code, 1'b0});
    check("t5_busy2", cyc, FRAME);

    // Test 6: all nibbles against all inject positions.
    for (int nib = 0; nib < 16; nib++) begin
      for (int k = 0; k < 8; k++) begin
        send_frame({3'(k), 4'(nib)}, bits, cyc, dn);
        code = model_code(4'(nib), 3'(k));
        check("t6_led",    {25'd0, led}, {25'd0, code});
        check("t6_frame",  {23'd0, bits}, {23'd0, 1'b1, led, 1'b0});
        check("t6_decode", {28'd0, model_decode(led)}, nib);
        check("t6_busy",   cyc, FRAME);
        check("t6_done",   {31'd0, dn}, 32'd1);
      end
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
